// File: rtl/carry8_seq_pkg.sv
// Shared types and constants for the byte-serial CARRY8 adder/subtractor.
// Holds the FSM state encoding, operation codes and byte width.
package carry8_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/CARRY8.sv
// Behavioural stand-in for the vendor CARRY8 fast-carry primitive.
// Combinational; DUAL_CY4 restarts the chain at bit 4 from CI_TOP.
module CARRY8 #(
    parameter string CARRY_TYPE = "SINGLE_CY8"
) (
    output logic [7:0] CO,
    output logic [7:0] O,
    input  logic       CI,
    input  logic       CI_TOP,
    input  logic [7:0] DI,
    input  logic [7:0] S
);

    localparam bit DUAL = (CARRY_TYPE == "DUAL_CY4");

    always_comb begin
        logic c;
        CO = '0;
        O  = '0;
        c  = CI;
        for (int i = 0; i < 8; i++) begin
            if (DUAL && i == 4) begin
                c = CI_TOP;
            end
            O[i]  = S[i] ^ c;
            // Propagate when S is set, otherwise generate from DI.
            CO[i] = S[i] ? c : DI[i];
            c     = CO[i];
        end
    end

endmodule

// File: rtl/carry8_seq_adder.sv
// Byte-serial add/subtract through one CARRY8; optional ZF/OVF via CARRY8_SEQ_FLAGS_EN.
// Latency: OUT_VLD rises NBYTES cycles after the accepting edge.
// Backpressure: one operation in flight; IN_RDY only in IDLE, result held until OUT_RDY.
module carry8_seq_adder
    import carry8_seq_pkg::*;
#(
    parameter int    NBYTES     = 4,
    parameter string CARRY_TYPE = "SINGLE_CY8"
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   IN_VLD,
    output logic                   IN_RDY,
    input  logic                   OP,
    input  logic                   CIN,
    input  logic [8*NBYTES-1:0]    A,
    input  logic [8*NBYTES-1:0]    B,
    output logic                   OUT_VLD,
    input  logic                   OUT_RDY,
    output logic [8*NBYTES-1:0]    SUM,
    output logic                   COUT
`ifdef CARRY8_SEQ_FLAGS_EN
    ,
    output logic                   ZF,
    output logic                   OVF
`endif
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t         state_q, state_nxt;
    logic [W-1:0]   a_q, b_q, sum_q, sum_nxt;
    logic           op_q, cy_q, cout_q;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     s_byte, co, o;
    logic           accept, last_byte;

    assign accept    = IN_VLD && IN_RDY;
    assign last_byte = (cnt_q == CW'(NBYTES - 1));

    // Subtraction is A + ~B + CIN, so CIN=1 means "no borrow in".
    assign s_byte = a_q[7:0] ^ ((op_q == OP_SUB) ? ~b_q[7:0] : b_q[7:0]);

    CARRY8 #(
        .CARRY_TYPE (CARRY_TYPE)
    ) u_carry8 (
        .CO     (co),
        .O      (o),
        .CI     (cy_q),
        .CI_TOP (cy_q),
        .DI     (a_q[7:0]),
        .S      (s_byte)
    );

    // Result is shifted in from the top so bytes land in place after NBYTES steps.
    assign sum_nxt = (sum_q >> BYTE_W) | (W'(o) << (W - BYTE_W));

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_byte) state_nxt = HOLD;
            HOLD:    if (OUT_RDY)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        IN_RDY  = (state_q == IDLE);
        OUT_VLD = (state_q == HOLD);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
            cy_q   <= 1'b0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= OP;
            cy_q  <= CIN;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            a_q   <= a_q >> BYTE_W;
            b_q   <= b_q >> BYTE_W;
            sum_q <= sum_nxt;
            cy_q  <= co[7];
            cnt_q <= last_byte ? '0 : cnt_q + CW'(1);
            if (last_byte) begin
                cout_q <= co[7];
            end
        end
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;

`ifdef CARRY8_SEQ_FLAGS_EN
    logic zf_q, ovf_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            zf_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_byte) begin
            zf_q  <= (sum_nxt == '0);
            ovf_q <= co[7] ^ co[6];
        end
    end

    assign ZF  = zf_q;
    assign OVF = ovf_q;

    logic unused_co;
    assign unused_co = ^co[5:0];
`else
    logic unused_co;
    assign unused_co = ^co[6:0];
`endif

endmodule

// File: tb/tb_carry8_seq_adder.sv
// Bench for carry8_seq_adder: arithmetic reference model plus directed literal cases.
// Covers NBYTES=4 (random + directed) and NBYTES=1 (directed + short random).
module tb_carry8_seq_adder;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn, in_vld, in_rdy, op, cin, out_vld, out_rdy, cout;
    logic [W-1:0] a, b, sum;
    logic         in_vld1, in_rdy1, op1, cin1, out_vld1, out_rdy1, cout1;
    logic [7:0]   a1, b1, sum1;
`ifdef CARRY8_SEQ_FLAGS_EN
    logic zf, ovf, zf1, ovf1;
`endif

    carry8_seq_adder #(.NBYTES(NB), .CARRY_TYPE("SINGLE_CY8")) dut (
        .CLK(clk), .RSTN(rstn), .IN_VLD(in_vld), .IN_RDY(in_rdy), .OP(op), .CIN(cin),
        .A(a), .B(b), .OUT_VLD(out_vld), .OUT_RDY(out_rdy), .SUM(sum), .COUT(cout)
`ifdef CARRY8_SEQ_FLAGS_EN
        , .ZF(zf), .OVF(ovf)
`endif
    );

    carry8_seq_adder #(.NBYTES(1), .CARRY_TYPE("SINGLE_CY8")) dut1 (
        .CLK(clk), .RSTN(rstn), .IN_VLD(in_vld1), .IN_RDY(in_rdy1), .OP(op1), .CIN(cin1),
        .A(a1), .B(b1), .OUT_VLD(out_vld1), .OUT_RDY(out_rdy1), .SUM(sum1), .COUT(cout1)
`ifdef CARRY8_SEQ_FLAGS_EN
        , .ZF(zf1), .OVF(ovf1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: full-width arithmetic at acceptance, result appears NB edges later.
    bit           m_init = 0, m_idle = 1, m_vld = 0;
    int           m_left = 0, m_acc = 0;
    logic [W-1:0] m_sum = '0, p_sum = '0;
    logic         m_cout = 0, p_cout = 0, m_zf = 0, p_zf = 0, m_ovf = 0, p_ovf = 0;

    always @(posedge clk) begin
        logic [W:0]   full;
        logic [W-1:0] bb;
        if (!rstn) begin
            m_init = 1; m_idle = 1; m_vld = 0; m_left = 0;
            m_sum = '0; m_cout = 0; m_zf = 0; m_ovf = 0;
        end else if (m_init) begin
            if (m_idle) begin
                if (in_vld) begin
                    bb     = op ? ~b : b;
                    full   = {1'b0, a} + {1'b0, bb} + (W+1)'(cin);
                    p_sum  = full[W-1:0];
                    p_cout = full[W];
                    p_zf   = (p_sum == '0);
                    p_ovf  = (a[W-1] == bb[W-1]) && (p_sum[W-1] != a[W-1]);
                    m_idle = 0;
                    m_left = NB;
                    m_acc++;
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_vld = 1; m_sum = p_sum; m_cout = p_cout; m_zf = p_zf; m_ovf = p_ovf;
                end
            end else if (out_rdy) begin
                m_vld  = 0;
                m_idle = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_rdy", in_rdy, m_idle);
            chk("out_vld", out_vld, m_vld);
            if (m_left == 0) begin
                chk("sum", sum, m_sum);
                chk("cout", cout, m_cout);
            end
`ifdef CARRY8_SEQ_FLAGS_EN
            if (m_vld) begin
                chk("zf", zf, m_zf);
                chk("ovf", ovf, m_ovf);
            end
`endif
        end
    end

    task automatic run_op(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic c, output int lat);
        op = o; a = aa; b = bb; cin = c; in_vld = 1;
        tick;
        in_vld = 0;
        a = $urandom; b = $urandom; op = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_vld && lat < 50) begin
            tick;
            lat++;
        end
    endtask

    task automatic release_result;
        out_rdy = 1;
        tick;
        out_rdy = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rstn = 0; in_vld = 0; out_rdy = 0; op = 0; cin = 0; a = '0; b = '0;
        in_vld1 = 0; out_rdy1 = 0; op1 = 0; cin1 = 0; a1 = '0; b1 = '0;
        repeat (3) tick;
        rstn = 1;
        chk("reset_in_rdy", in_rdy, 1);
        chk("reset_out_vld", out_vld, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);

        run_op(0, 32'h0000_00FF, 32'h0000_0001, 0, lat);
        chk("add_carry_latency", lat, NB);
        chk("add_carry_sum", sum, 32'h0000_0100);
        chk("add_carry_cout", cout, 0);
        release_result;

        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 0, lat);
        chk("add_wrap_sum", sum, 0);
        chk("add_wrap_cout", cout, 1);
`ifdef CARRY8_SEQ_FLAGS_EN
        chk("add_wrap_zf", zf, 1);
`endif
        release_result;

        run_op(1, 32'd5, 32'd7, 1, lat);
        chk("sub_neg_sum", sum, 32'hFFFF_FFFE);
        chk("sub_neg_cout", cout, 0);
        release_result;

        run_op(1, 32'h8000_0000, 32'd1, 1, lat);
        chk("sub_ovf_sum", sum, 32'h7FFF_FFFF);
        chk("sub_ovf_cout", cout, 1);
`ifdef CARRY8_SEQ_FLAGS_EN
        chk("sub_ovf_ovf", ovf, 1);
`endif
        release_result;

        // Stall in HOLD with a stray request fired during RUN.
        op = 0; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1; in_vld = 1;
        tick;
        in_vld = 0;
        tick;
        chk("run_in_rdy", in_rdy, 0);
        in_vld = 1; a = '0; b = '0; cin = 0;
        tick;
        in_vld = 0;
        lat = 0;
        while (!out_vld && lat < 50) begin
            tick;
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("hold_vld", out_vld, 1);
            chk("hold_sum", sum, 32'h2345_678A);
            chk("hold_in_rdy", in_rdy, 0);
            tick;
        end
        release_result;
        chk("dropped_out_vld", out_vld, 0);
        tick;
        chk("idle_keep_sum", sum, 32'h2345_678A);
        chk("idle_in_rdy", in_rdy, 1);

        // Reset in the middle of RUN discards the partial result.
        op = 0; a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1; in_vld = 1;
        tick;
        in_vld = 0;
        tick;
        tick;
        rstn = 0;
        tick;
        rstn = 1;
        chk("abort_out_vld", out_vld, 0);
        chk("abort_sum", sum, 0);
        chk("abort_in_rdy", in_rdy, 1);
        chk("abort_cout", cout, 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("abort_no_vld", out_vld, 0);
        end

        // Single-byte instance.
        a1 = 8'h80; b1 = 8'h80; op1 = 0; cin1 = 0; in_vld1 = 1;
        tick;
        in_vld1 = 0;
        lat = 0;
        while (!out_vld1 && lat < 50) begin
            tick;
            lat++;
        end
        chk("nb1_latency", lat, 1);
        chk("nb1_sum", sum1, 8'h00);
        chk("nb1_cout", cout1, 1);
`ifdef CARRY8_SEQ_FLAGS_EN
        chk("nb1_zf", zf1, 1);
        chk("nb1_ovf", ovf1, 1);
`endif
        out_rdy1 = 1;
        tick;
        out_rdy1 = 0;
        for (int i = 0; i < 20; i++) begin
            logic [8:0] e;
            logic [7:0] ra, rb;
            logic       ro, rc;
            ra = 8'($urandom); rb = 8'($urandom); ro = 1'($urandom); rc = 1'($urandom);
            e = {1'b0, ra} + {1'b0, (ro ? ~rb : rb)} + 9'(rc);
            a1 = ra; b1 = rb; op1 = ro; cin1 = rc; in_vld1 = 1;
            tick;
            in_vld1 = 0;
            lat = 0;
            while (!out_vld1 && lat < 50) begin
                tick;
                lat++;
            end
            chk("nb1_rand", {cout1, sum1}, e);
            out_rdy1 = 1;
            tick;
            out_rdy1 = 0;
        end

        // Random traffic on the 4-byte instance against the model.
        m_acc = 0;
        for (int i = 0; i < 3000; i++) begin
            in_vld  = ($urandom_range(0, 2) == 0);
            out_rdy = 1'($urandom);
            a = $urandom; b = $urandom; op = 1'($urandom); cin = 1'($urandom);
            rstn = ($urandom_range(0, 299) != 0);
            tick;
        end
        rstn = 1; in_vld = 0; out_rdy = 1;
        repeat (10) tick;
        chk("random_accepts", (m_acc > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carry8_seq_adder.md
CARRY8_SEQ_ADDER -- requirements
Module: carry8_seq_adder

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving operand width in bytes (legal 1..16).
REQ-002 SHALL have parameter CARRY_TYPE, default "SINGLE_CY8", passed unchanged to the CARRY8 instance.
REQ-003 SHALL have port CLK, input, 1, the only clock; all state updates on rising edge.
REQ-004 SHALL have port RSTN, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port IN_VLD, input, 1, request valid.
REQ-006 SHALL have port IN_RDY, output, 1, block can accept a request.
REQ-007 SHALL have port OP, input, 1, operation: 0 = A+B+CIN, 1 = A-B-!CIN (borrow-style).
REQ-008 SHALL have port CIN, input, 1, carry-in to byte 0.
REQ-009 SHALL have port A, input, 8*NBYTES, first operand.
REQ-010 SHALL have port B, input, 8*NBYTES, second operand.
REQ-011 SHALL have port OUT_VLD, output, 1, result valid.
REQ-012 SHALL have port OUT_RDY, input, 1, consumer accepts result.
REQ-013 SHALL have port SUM, output, 8*NBYTES, result.
REQ-014 SHALL have port COUT, output, 1, carry out of most significant byte.

Function
REQ-015 SHALL compute one byte per cycle through one CARRY8 instance: S = A_byte ^ B_byte' (B_byte' = ~B_byte when OP=1), DI = A_byte, CI = carry register, CI_TOP tied to carry register, sum byte = O.
REQ-016 SHALL take the carry register from CO[7] after each byte; on acceptance it loads CIN when OP=0, CIN when OP=1 (CIN=1 means no borrow).
REQ-017 SHALL have FSM states IDLE, RUN, HOLD; IDLE->RUN on IN_VLD&IN_RDY; RUN->HOLD after byte NBYTES-1; HOLD->IDLE on OUT_RDY.
REQ-018 SHALL assert IN_RDY only in IDLE; requests with IN_VLD in RUN/HOLD are ignored, not queued.
REQ-019 SHALL latch A, B, OP at acceptance; later changes on A/B/OP have no effect on the running operation.
REQ-020 SHALL process bytes LSB first; byte index counter wraps to 0 on RUN exit.
REQ-021 SHALL assert OUT_VLD exactly NBYTES cycles after the acceptance edge and hold SUM, COUT, OUT_VLD stable until OUT_RDY sampled high.
REQ-022 SHALL, for NBYTES=1, enter HOLD one cycle after acceptance.
REQ-023 SHALL keep SUM/COUT unchanged in IDLE (last result retained).

Reset
REQ-024 SHALL, with RSTN low at a rising edge, force state IDLE, byte counter 0, carry register 0, SUM 0, COUT 0, OUT_VLD 0, IN_RDY 1 on the next cycle.
REQ-025 SHALL abort a RUN or HOLD operation when reset occurs; the partial result is discarded, no OUT_VLD issued.

Configuration
REQ-026 SHALL support macro CARRY8_SEQ_FLAGS_EN; when defined, add outputs ZF (1: SUM all zero) and OVF (1: signed overflow, CO[7]^CO[6] of final byte), valid and held with OUT_VLD, reset 0.
REQ-027 SHALL, without CARRY8_SEQ_FLAGS_EN, omit ZF/OVF ports and their logic entirely.

Structure
REQ-028 SHALL place FSM state enum (IDLE, RUN, HOLD), OP encodings (OP_ADD=0, OP_SUB=1) and byte-width constant 8 in shared package carry8_seq_pkg.
REQ-029 SHALL instantiate the existing CARRY8 primitive as its single sub-module; no other sub-module.

Verification
REQ-030 SHALL cover: NBYTES=4, OP=0, A=0x0000_00FF, B=0x0000_0001, CIN=0 -> SUM=0x0000_0100, COUT=0, OUT_VLD 4 cycles after accept.
REQ-031 SHALL cover: OP=0, A=0xFFFF_FFFF, B=0x0000_0001, CIN=0 -> SUM=0, COUT=1 (ZF=1 with flags).
REQ-032 SHALL cover: OP=1, A=5, B=7, CIN=1 -> SUM=0xFFFF_FFFE, COUT=0; with flags, A=0x8000_0000, B=1 -> OVF=1.
REQ-033 SHALL cover: OUT_RDY low 10 cycles during HOLD, second IN_VLD pulse during RUN -> result stable, IN_RDY=0, second request dropped.
REQ-034 SHALL cover: RSTN low at byte 2 of RUN -> next cycle IDLE, OUT_VLD=0, SUM=0, IN_RDY=1.
REQ-035 SHALL cover: NBYTES=1, A=0x80, B=0x80, OP=0 -> SUM=0x00, COUT=1, OUT_VLD 1 cycle after accept.
